// File: rtl/hdmi_tx_pattern_gen.sv
// AXI4-Stream video test-frame source for the HDMI TX path.
// Emits solid / ramp / colour-bar / checker frames with programmable size and idle gaps.
module hdmi_tx_pattern_gen #(
  parameter int C_LINE_GAP  = 4,
  parameter int C_FRAME_GAP = 16
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        i_enable,
  input  logic [12:0] i_h_active,
  input  logic [11:0] i_v_active,
  input  logic [1:0]  i_pattern,
  input  logic [23:0] i_solid,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [47:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        o_busy,
  output logic [31:0] o_frame_cnt
);

  typedef enum logic [1:0] {IDLE, LINE, LINE_GAP, FRAME_GAP} state_t;

  localparam logic [15:0] LG_LAST = (C_LINE_GAP  > 0) ? 16'(C_LINE_GAP  - 1) : 16'd0;
  localparam logic [15:0] FG_LAST = (C_FRAME_GAP > 0) ? 16'(C_FRAME_GAP - 1) : 16'd0;

  state_t      r_state;
  logic [12:0] r_h, r_col, r_bw, r_bar_cnt;
  logic [11:0] r_v, r_row;
  logic [2:0]  r_bar;
  logic [1:0]  r_pat;
  logic [23:0] r_solid;
  logic [15:0] r_gap;
  logic        r_tvalid, r_tlast, r_tuser;
  logic [47:0] r_tdata;
  logic [31:0] r_frame_cnt;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  function automatic logic [47:0] pix(input logic [1:0] pat, input logic [23:0] solid,
                                      input logic [12:0] col, input logic [11:0] row,
                                      input logic [2:0] bar);
    case (pat)
      2'd0:    pix = {solid, solid};
      2'd1:    pix = {{3{col[6:0], 1'b1}}, {3{col[6:0], 1'b0}}};
      2'd2:    pix = {bar_colour(bar), bar_colour(bar)};
      default: pix = (col[4] ^ row[4]) ? {48{1'b1}} : 48'd0;
    endcase
  endfunction

  logic        w_xfer, w_eol, w_eof, w_cfg_ok, w_bar_step, w_frame_done, w_launch;
  logic [12:0] w_start_bw, w_nx_col, w_nx_bar_cnt;
  logic [11:0] w_nl_row;
  logic [2:0]  w_nx_bar;
  logic [47:0] w_start_data, w_nx_data, w_nl_data;

  assign w_xfer       = r_tvalid & m_axis_tready;
  assign w_eol        = (r_col == r_h - 13'd1);
  assign w_eof        = (r_row == r_v - 12'd1);
  assign w_cfg_ok     = i_enable & (|i_h_active) & (|i_v_active);
  assign w_start_bw   = (i_h_active[12:3] == 10'd0) ? 13'd1 : {3'd0, i_h_active[12:3]};
  assign w_nx_col     = r_col + 13'd1;
  assign w_bar_step   = (r_bar_cnt == r_bw - 13'd1);
  assign w_nx_bar_cnt = w_bar_step ? 13'd0 : r_bar_cnt + 13'd1;
  assign w_nx_bar     = (w_bar_step && r_bar != 3'd7) ? r_bar + 3'd1 : r_bar;
  // Row is already advanced while sitting in LINE_GAP; only the zero-gap path needs +1.
  assign w_nl_row     = (r_state == LINE) ? r_row + 12'd1 : r_row;
  assign w_start_data = pix(i_pattern, i_solid, 13'd0, 12'd0, 3'd0);
  assign w_nx_data    = pix(r_pat, r_solid, w_nx_col, r_row, w_nx_bar);
  assign w_nl_data    = pix(r_pat, r_solid, 13'd0, w_nl_row, 3'd0);

  assign w_frame_done = ((r_state == FRAME_GAP) && (r_gap == FG_LAST)) ||
                        ((C_FRAME_GAP == 0) && (r_state == LINE) && w_xfer && w_eol && w_eof);
  assign w_launch     = ((r_state == IDLE) || w_frame_done) && w_cfg_ok;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state     <= IDLE;
      r_h         <= '0;
      r_v         <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_bw        <= '0;
      r_bar       <= '0;
      r_bar_cnt   <= '0;
      r_pat       <= '0;
      r_solid     <= '0;
      r_gap       <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_tdata     <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        LINE: if (w_xfer) begin
          if (!w_eol) begin
            r_col     <= w_nx_col;
            r_bar     <= w_nx_bar;
            r_bar_cnt <= w_nx_bar_cnt;
            r_tdata   <= w_nx_data;
            r_tuser   <= 1'b0;
            r_tlast   <= (w_nx_col == r_h - 13'd1);
          end else if (!w_eof) begin
            r_col     <= '0;
            r_row     <= w_nl_row;
            r_bar     <= '0;
            r_bar_cnt <= '0;
            if (C_LINE_GAP == 0) begin
              r_tdata <= w_nl_data;
              r_tuser <= 1'b0;
              r_tlast <= (r_h == 13'd1);
            end else begin
              r_tvalid <= 1'b0;
              r_gap    <= '0;
              r_state  <= LINE_GAP;
            end
          end else begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_gap       <= '0;
            r_state     <= (C_FRAME_GAP == 0) ? IDLE : FRAME_GAP;
          end
        end
        LINE_GAP: if (r_gap == LG_LAST) begin
          r_state  <= LINE;
          r_tvalid <= 1'b1;
          r_tdata  <= w_nl_data;
          r_tuser  <= 1'b0;
          r_tlast  <= (r_h == 13'd1);
        end else begin
          r_gap <= r_gap + 16'd1;
        end
        FRAME_GAP: if (r_gap == FG_LAST) r_state <= IDLE;
                   else                  r_gap   <= r_gap + 16'd1;
        default: ;
      endcase
      // Frame start overrides whatever the case above chose (IDLE or end-of-frame).
      if (w_launch) begin
        r_state   <= LINE;
        r_h       <= i_h_active;
        r_v       <= i_v_active;
        r_pat     <= i_pattern;
        r_solid   <= i_solid;
        r_bw      <= w_start_bw;
        r_col     <= '0;
        r_row     <= '0;
        r_bar     <= '0;
        r_bar_cnt <= '0;
        r_tvalid  <= 1'b1;
        r_tdata   <= w_start_data;
        r_tuser   <= 1'b1;
        r_tlast   <= (i_h_active == 13'd1);
      end
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign o_busy        = (r_state != IDLE);
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_hdmi_tx_pattern_gen.sv
// Directed bench for hdmi_tx_pattern_gen: one task per scenario, inline checks.
module tb_hdmi_tx_pattern_gen;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        i_enable = 1'b0;
  logic [12:0] i_h_active = '0;
  logic [11:0] i_v_active = '0;
  logic [1:0]  i_pattern = '0;
  logic [23:0] i_solid = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [47:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        o_busy;
  logic [31:0] o_frame_cnt;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;

  always #5 ACLK = ~ACLK;

  hdmi_tx_pattern_gen #(.C_LINE_GAP(4), .C_FRAME_GAP(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .i_enable(i_enable), .i_h_active(i_h_active),
    .i_v_active(i_v_active), .i_pattern(i_pattern), .i_solid(i_solid),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .o_busy(o_busy),
    .o_frame_cnt(o_frame_cnt)
  );

  function automatic logic [23:0] exp_bar(input int b);
    case (b)
      0: exp_bar = 24'hFFFFFF; 1: exp_bar = 24'hFFFF00; 2: exp_bar = 24'h00FFFF;
      3: exp_bar = 24'h00FF00; 4: exp_bar = 24'hFF00FF; 5: exp_bar = 24'hFF0000;
      6: exp_bar = 24'h0000FF; default: exp_bar = 24'h000000;
    endcase
  endfunction

  task automatic wait_idle(input int bound, output bit ok, output bit vld_seen);
    ok = 0; vld_seen = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge ACLK);
      if (m_axis_tvalid) vld_seen = 1;
      if (!o_busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    ARESETN = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    total++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, o_busy} !== 4'b0 || m_axis_tdata !== 48'd0 ||
        o_frame_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_state got v=%b l=%b u=%b busy=%b d=%h fc=%0d exp all zero",
               m_axis_tvalid, m_axis_tlast, m_axis_tuser, o_busy, m_axis_tdata, o_frame_cnt);
    end
    ARESETN = 1;
  endtask

  task automatic test_solid();
    int beats = 0, gap = 0, cyc = 0;
    bit seen_last = 0, ok, vs;
    i_h_active = 4; i_v_active = 3; i_pattern = 0; i_solid = 24'h123456; m_axis_tready = 1;
    i_enable = 1;
    while (beats < 12 && cyc < 500) begin
      @(negedge ACLK); cyc++;
      if (m_axis_tvalid) begin
        i_enable = 0;
        if (seen_last) begin
          total++;
          if (gap !== 4) begin bad++; $display("FAIL solid_line_gap got=%0d exp=4", gap); end
        end
        seen_last = 0; gap = 0;
        total++;
        if (m_axis_tdata !== 48'h123456123456 || m_axis_tuser !== (beats == 0) ||
            m_axis_tlast !== (beats % 4 == 3)) begin
          bad++;
          $display("FAIL solid_beat%0d got d=%h u=%b l=%b exp d=123456123456 u=%b l=%b", beats,
                   m_axis_tdata, m_axis_tuser, m_axis_tlast, beats == 0, beats % 4 == 3);
        end
        if (m_axis_tlast) seen_last = (beats < 11);
        beats++;
      end else if (seen_last) gap++;
    end
    total++;
    if (beats != 12) begin bad++; $display("FAIL solid_timeout got beats=%0d exp=12", beats); end
    @(negedge ACLK);
    exp_frames++;
    total++;
    if (o_frame_cnt !== 32'(exp_frames)) begin
      bad++; $display("FAIL solid_frame_cnt got=%0d exp=%0d", o_frame_cnt, exp_frames);
    end
    wait_idle(40, ok, vs);
    total++;
    if (!ok || vs) begin bad++; $display("FAIL solid_to_idle got ok=%b vld=%b exp ok=1 vld=0", ok, vs); end
  endtask

  task automatic test_backpressure();
    int beats = 0, cyc = 0, stalls = 0;
    bit stalled = 0, ok, vs;
    logic [47:0] pd; logic pl, pu;
    i_h_active = 4; i_v_active = 3; i_pattern = 0; i_solid = 24'h123456; i_enable = 1;
    while (beats < 12 && cyc < 2000) begin
      @(negedge ACLK); cyc++;
      m_axis_tready = 1'($urandom_range(0, 1));
      if (stalled) begin
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl || m_axis_tuser !== pu) begin
          bad++;
          $display("FAIL bp_hold got v=%b d=%h l=%b u=%b exp v=1 d=%h l=%b u=%b", m_axis_tvalid,
                   m_axis_tdata, m_axis_tlast, m_axis_tuser, pd, pl, pu);
        end
      end
      stalled = 0;
      if (m_axis_tvalid) begin
        i_enable = 0;
        if (m_axis_tready) begin
          total++;
          if (m_axis_tdata !== 48'h123456123456 || m_axis_tuser !== (beats == 0) ||
              m_axis_tlast !== (beats % 4 == 3)) begin
            bad++;
            $display("FAIL bp_beat%0d got d=%h u=%b l=%b exp u=%b l=%b", beats, m_axis_tdata,
                     m_axis_tuser, m_axis_tlast, beats == 0, beats % 4 == 3);
          end
          beats++;
        end else begin
          stalled = 1; stalls++;
          pd = m_axis_tdata; pl = m_axis_tlast; pu = m_axis_tuser;
        end
      end
    end
    m_axis_tready = 1;
    total++;
    if (beats != 12) begin bad++; $display("FAIL bp_timeout got beats=%0d exp=12", beats); end
    exp_frames++;
    wait_idle(40, ok, vs);
    total++;
    if (!ok || o_frame_cnt !== 32'(exp_frames)) begin
      bad++; $display("FAIL bp_frame_end got ok=%b fc=%0d exp ok=1 fc=%0d", ok, o_frame_cnt, exp_frames);
    end
  endtask

  task automatic test_bars();
    int beats = 0, cyc = 0, b;
    bit ok, vs;
    logic [23:0] c;
    i_h_active = 64; i_v_active = 1; i_pattern = 2; i_enable = 1;
    while (beats < 64 && cyc < 500) begin
      @(negedge ACLK); cyc++;
      if (m_axis_tvalid) begin
        i_enable = 0;
        b = (beats / 8 > 7) ? 7 : beats / 8;
        c = exp_bar(b);
        total++;
        if (m_axis_tdata !== {c, c} || m_axis_tlast !== (beats == 63) || m_axis_tuser !== (beats == 0)) begin
          bad++;
          $display("FAIL bars_beat%0d got d=%h l=%b u=%b exp d=%h%h l=%b u=%b", beats, m_axis_tdata,
                   m_axis_tlast, m_axis_tuser, c, c, beats == 63, beats == 0);
        end
        beats++;
      end
    end
    total++;
    if (beats != 64) begin bad++; $display("FAIL bars_timeout got beats=%0d exp=64", beats); end
    exp_frames++;
    wait_idle(40, ok, vs);
  endtask

  task automatic test_h1();
    int beats = 0, cyc = 0;
    bit ok, vs;
    i_h_active = 1; i_v_active = 2; i_pattern = 1; i_enable = 1;
    while (beats < 2 && cyc < 200) begin
      @(negedge ACLK); cyc++;
      if (m_axis_tvalid) begin
        i_enable = 0;
        total++;
        if (m_axis_tdata !== 48'h010101000000 || m_axis_tlast !== 1'b1 || m_axis_tuser !== (beats == 0)) begin
          bad++;
          $display("FAIL h1_beat%0d got d=%h l=%b u=%b exp d=010101000000 l=1 u=%b", beats,
                   m_axis_tdata, m_axis_tlast, m_axis_tuser, beats == 0);
        end
        beats++;
      end
    end
    total++;
    if (beats != 2) begin bad++; $display("FAIL h1_timeout got beats=%0d exp=2", beats); end
    exp_frames++;
    wait_idle(40, ok, vs);
    total++;
    if (!ok || o_frame_cnt !== 32'(exp_frames)) begin
      bad++; $display("FAIL h1_frame_end got ok=%b fc=%0d exp ok=1 fc=%0d", ok, o_frame_cnt, exp_frames);
    end
  endtask

  task automatic test_enable_drop();
    int beats = 0, cyc = 0;
    bit ok, vs;
    i_h_active = 2; i_v_active = 3; i_pattern = 3; i_enable = 1;
    while (beats < 6 && cyc < 300) begin
      @(negedge ACLK); cyc++;
      if (m_axis_tvalid) begin
        if (beats == 2) i_enable = 0;
        total++;
        if (m_axis_tdata !== 48'd0 || m_axis_tlast !== (beats % 2 == 1)) begin
          bad++;
          $display("FAIL endrop_beat%0d got d=%h l=%b exp d=0 l=%b", beats, m_axis_tdata,
                   m_axis_tlast, beats % 2 == 1);
        end
        beats++;
      end
    end
    total++;
    if (beats != 6) begin bad++; $display("FAIL endrop_timeout got beats=%0d exp=6", beats); end
    exp_frames++;
    wait_idle(40, ok, vs);
    total++;
    if (!ok || vs || o_busy !== 1'b0 || o_frame_cnt !== 32'(exp_frames)) begin
      bad++;
      $display("FAIL endrop_idle got ok=%b vld=%b busy=%b fc=%0d exp ok=1 vld=0 busy=0 fc=%0d",
               ok, vs, o_busy, o_frame_cnt, exp_frames);
    end
  endtask

  task automatic test_bad_cfg();
    bit hit = 0;
    i_h_active = 0; i_v_active = 3; i_enable = 1;
    repeat (10) begin @(negedge ACLK); if (m_axis_tvalid || o_busy) hit = 1; end
    total++;
    if (hit) begin bad++; $display("FAIL h0_stays_idle got active=1 exp=0"); end
    hit = 0; i_h_active = 4; i_v_active = 0;
    repeat (10) begin @(negedge ACLK); if (m_axis_tvalid || o_busy) hit = 1; end
    total++;
    if (hit) begin bad++; $display("FAIL v0_stays_idle got active=1 exp=0"); end
    i_enable = 0;
  endtask

  task automatic test_mid_reset();
    int beats = 0, cyc = 0;
    bit found = 0;
    i_h_active = 8; i_v_active = 2; i_pattern = 1; i_enable = 1;
    while (beats < 3 && cyc < 100) begin
      @(negedge ACLK); cyc++;
      if (m_axis_tvalid) beats++;
    end
    ARESETN = 0;
    @(negedge ACLK);
    exp_frames = 0;
    total++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 3'b0 || o_frame_cnt !== 32'd0) begin
      bad++;
      $display("FAIL midreset_clear got v=%b l=%b u=%b fc=%0d exp all zero", m_axis_tvalid,
               m_axis_tlast, m_axis_tuser, o_frame_cnt);
    end
    ARESETN = 1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge ACLK);
      if (m_axis_tvalid) begin
        found = 1;
        total++;
        if (m_axis_tuser !== 1'b1 || m_axis_tdata !== 48'h010101000000 || m_axis_tlast !== 1'b0) begin
          bad++;
          $display("FAIL midreset_restart got u=%b d=%h l=%b exp u=1 d=010101000000 l=0",
                   m_axis_tuser, m_axis_tdata, m_axis_tlast);
        end
      end
    end
    total++;
    if (!found) begin bad++; $display("FAIL midreset_timeout got no beat exp restart"); end
    i_enable = 0;
    ARESETN = 0;
    @(negedge ACLK);
    ARESETN = 1;
  endtask

  initial begin
    test_reset();
    test_solid();
    test_backpressure();
    test_bars();
    test_h1();
    test_enable_drop();
    test_bad_cfg();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
